operand_forward: RTL

- Producer-side companion to the two-cycle ALU. It supplies the ALU's input operands and decides when an instruction may issue.
- Tracks destination registers of up to three in-flight instructions (stages E1, E2, E3) and resolves each source register to the youngest in-flight value or to register-file data.
- Asserts a stall when a needed value is not yet produced.
- Sits between decode/register-read and the ALU inputs.

---
 rtl/operand_forward.sv | 120 ++++++++++++
 1 files changed

// File: rtl/operand_forward.sv
// Operand resolution for the two-cycle ALU: tracks rd/kind of the E1..E3
// instructions, forwards the youngest in-flight value and stalls issue until it exists.

module operand_forward_src #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0]       rs,
    input  logic                      used,
    input  logic [XLEN-1:0]           rf_data,
    input  logic [2:0]                vld_pipe,
    input  logic [2:0][REG_BITS-1:0]  e_rd,
    input  logic [2:0][1:0]           e_kind,
    input  logic [2:0][XLEN-1:0]      stage_data,
    output logic [XLEN-1:0]           op,
    output logic                      hazard
);
    logic hit;

    // Stage index s (0 = E1) holds a usable value once s+1 >= kind;
    // the first (youngest) match decides, available or not.
    always_comb begin
        op     = rf_data;
        hazard = 1'b0;
        hit    = 1'b0;
        if (used && rs == '0) begin
            op = '0;
        end else if (used) begin
            for (int s = 0; s < 3; s++) begin
                if (!hit && vld_pipe[s] && e_rd[s] == rs && e_kind[s] != 2'd0) begin
                    hit = 1'b1;
                    if ({1'b0, e_kind[s]} <= 3'(s + 1))
                        op = stage_data[s];
                    else
                        hazard = 1'b1;
                end
            end
        end
    end
endmodule

module operand_forward #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_rs1,
    input  logic [REG_BITS-1:0] dec_rs2,
    input  logic                dec_rs1_used,
    input  logic                dec_rs2_used,
    input  logic [REG_BITS-1:0] dec_rd,
    input  logic [1:0]          dec_kind,
    input  logic [XLEN-1:0]     rf_rs1_data,
    input  logic [XLEN-1:0]     rf_rs2_data,
    input  logic [XLEN-1:0]     e1_add_data,
    input  logic [XLEN-1:0]     e2_result_data,
    input  logic [XLEN-1:0]     e3_load_data,
    input  logic                flush,
    output logic                issue,
    output logic                stall,
    output logic [XLEN-1:0]     op_a,
    output logic [XLEN-1:0]     op_b
);
    localparam int STAGES = 2;

    logic [STAGES:0]                vld_pipe;
    logic [STAGES:0][REG_BITS-1:0]  e_rd;
    logic [STAGES:0][1:0]           e_kind;
    logic                           active;

    logic [1:0][REG_BITS-1:0]       src_rs;
    logic [1:0]                     src_used;
    logic [1:0][XLEN-1:0]           src_rf;
    logic [1:0][XLEN-1:0]           src_op;
    logic [1:0]                     src_haz;
    logic [STAGES:0][XLEN-1:0]      stage_data;
    logic                           go;

    assign src_rs     = {dec_rs2, dec_rs1};
    assign src_used   = {dec_rs2_used, dec_rs1_used};
    assign src_rf     = {rf_rs2_data, rf_rs1_data};
    assign stage_data = {e3_load_data, e2_result_data, e1_add_data};

    for (genvar g = 0; g < 2; g++) begin : g_src
        operand_forward_src #(.XLEN(XLEN), .REG_BITS(REG_BITS)) u_src (
            .rs         (src_rs[g]),
            .used       (src_used[g]),
            .rf_data    (src_rf[g]),
            .vld_pipe   (vld_pipe),
            .e_rd       (e_rd),
            .e_kind     (e_kind),
            .stage_data (stage_data),
            .op         (src_op[g]),
            .hazard     (src_haz[g])
        );
    end

    // active holds everything quiet from reset until the first clock after release.
    assign go    = active & dec_valid & ~flush;
    assign stall = go & (|src_haz);
    assign issue = go & ~(|src_haz);
    assign op_a  = active ? src_op[0] : '0;
    assign op_b  = active ? src_op[1] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            vld_pipe <= '0;
            e_rd     <= '0;
            e_kind   <= '0;
        end else begin
            active   <= 1'b1;
            vld_pipe <= flush ? '0 : {vld_pipe[STAGES-1:0], issue};
            e_rd     <= {e_rd[STAGES-1:0], dec_rd};
            e_kind   <= {e_kind[STAGES-1:0], dec_kind};
        end
    end
endmodule
